// File: rtl/core_pkg.sv
// Shared core definitions used by the load/store unit: opcodes, funct3 size
// encodings, exception causes and the LSU state type.
package core_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // size is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Lane alignment for the LSU: store byte enables/data shifted to the access
// offset, and load data shifted down and sign/zero-extended by funct3.
module core_lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] load_val
);

  logic [7:0]  be_base;
  logic [63:0] x;

  always_comb begin
    case (funct3[1:0])
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be    = be_base << off;
    wdata = store_data << {off, 3'b000};
    x     = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    load_val = {{56{x[7]}}, x[7:0]};
      F3_H:    load_val = {{48{x[15]}}, x[15:0]};
      F3_W:    load_val = {{32{x[31]}}, x[31:0]};
      F3_D:    load_val = x;
      F3_BU:   load_val = {56'b0, x[7:0]};
      F3_HU:   load_val = {48'b0, x[15:0]};
      F3_WU:   load_val = {32'b0, x[31:0]};
      default: load_val = x;
    endcase
  end

endmodule

// File: rtl/core_load_store_unit.sv
// RV64 load/store unit: one outstanding req/gnt/rvalid transaction per access.
// Optional LSU_TIMEOUT_EN macro adds a wait-cycle limit raising an access fault.
//   state  | meaning
//   IDLE   | req_ready=1, waiting to accept
//   REQ    | mem_req held until mem_gnt
//   WAIT   | granted, waiting for mem_rvalid
//   RESP   | one-cycle resp_valid / exception report
module core_load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        resp_valid,
  output logic        resp_wr_en,
  output logic [4:0]  resp_rd,
  output logic [63:0] load_data,
  output logic        exc_valid,
  output logic [3:0]  exc_cause,
  output logic [63:0] exc_tval
);

  lsu_state_t  state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] sdata_q;
  logic [4:0]  rd_q;
  logic        req_ready_q;
  logic        mem_req_q;
  logic        resp_valid_q;
  logic        resp_wr_en_q;
  logic [4:0]  resp_rd_q;
  logic [63:0] load_data_q;
  logic        exc_valid_q;
  logic [3:0]  exc_cause_q;
  logic [63:0] exc_tval_q;

  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] load_val;

  logic        accept;
  logic        in_load;
  logic        in_store;
  logic        in_illegal;
  logic        in_misalign;
  logic        mem_done;
  logic        timeout_hit;
  logic        done;
  logic        done_exc;
  logic [3:0]  done_cause;
  logic [63:0] done_tval;
  logic        done_wr_en;

  core_lsu_align u_align (
    .funct3     (funct3_q),
    .off        (addr_q[2:0]),
    .store_data (sdata_q),
    .rdata      (mem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_val   (load_val)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Only IDLE leads to REQ, so clearing in IDLE is clearing on entry to REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == S_REQ || state == S_WAIT)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  assign timeout_hit = (state == S_REQ || state == S_WAIT) &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    accept      = (state == S_IDLE) && req_valid;
    in_load     = (req_opcode == OP_LOAD);
    in_store    = (req_opcode == OP_STORE);
    in_illegal  = !(in_load || in_store) ||
                  (in_load && req_funct3 == 3'b111) ||
                  (in_store && req_funct3[2]);
    in_misalign = misaligned(req_funct3[1:0], req_addr[2:0]);
    mem_done    = ((state == S_REQ && mem_gnt) || state == S_WAIT) && mem_rvalid;

    done       = 1'b0;
    done_exc   = 1'b0;
    done_cause = 4'd0;
    done_tval  = 64'd0;
    done_wr_en = 1'b0;
    if (accept) begin
      if (in_illegal) begin
        done       = 1'b1;
        done_exc   = 1'b1;
        done_cause = CAUSE_ILLEGAL;
        done_tval  = req_addr;
      end else if (in_misalign) begin
        done       = 1'b1;
        done_exc   = 1'b1;
        done_cause = in_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
        done_tval  = req_addr;
      end
    end else if (mem_done) begin
      done       = 1'b1;
      done_exc   = mem_err;
      done_cause = mem_err ? (is_store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT) : 4'd0;
      done_tval  = mem_err ? addr_q : 64'd0;
      done_wr_en = !is_store_q && !mem_err && (rd_q != 5'd0);
    end else if (timeout_hit) begin
      done       = 1'b1;
      done_exc   = 1'b1;
      done_cause = is_store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
      done_tval  = addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 64'd0;
      sdata_q      <= 64'd0;
      rd_q         <= 5'd0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_wr_en_q <= 1'b0;
      resp_rd_q    <= 5'd0;
      load_data_q  <= 64'd0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= 4'd0;
      exc_tval_q   <= 64'd0;
    end else begin
      // Response fields live for exactly the RESP cycle.
      resp_valid_q <= 1'b0;
      resp_wr_en_q <= 1'b0;
      resp_rd_q    <= 5'd0;
      load_data_q  <= 64'd0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= 4'd0;
      exc_tval_q   <= 64'd0;

      if (accept) begin
        is_store_q <= in_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        sdata_q    <= req_store_data;
        rd_q       <= req_rd;
      end

      if (done) begin
        state        <= S_RESP;
        req_ready_q  <= 1'b0;
        mem_req_q    <= 1'b0;
        resp_valid_q <= 1'b1;
        resp_wr_en_q <= done_wr_en;
        resp_rd_q    <= accept ? req_rd : rd_q;
        load_data_q  <= (done_exc || is_store_q) ? 64'd0 : load_val;
        exc_valid_q  <= done_exc;
        exc_cause_q  <= done_cause;
        exc_tval_q   <= done_tval;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state       <= S_REQ;
              req_ready_q <= 1'b0;
              mem_req_q   <= 1'b1;
            end
          end
          S_REQ: begin
            if (mem_gnt) begin
              state     <= S_WAIT;
              mem_req_q <= 1'b0;
            end
          end
          S_WAIT: ;
          S_RESP: begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = {addr_q[63:3], 3'b000};
  assign mem_we     = mem_req_q & is_store_q;
  assign mem_be     = mem_req_q ? be : 8'h00;
  assign mem_wdata  = wdata;
  assign resp_valid = resp_valid_q;
  assign resp_wr_en = resp_wr_en_q;
  assign resp_rd    = resp_rd_q;
  assign load_data  = load_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;
  assign exc_tval   = exc_tval_q;

endmodule

// File: tb/tb_core_load_store_unit.sv
// Directed self-checking bench for core_load_store_unit; the timeout scenario
// runs only when LSU_TIMEOUT_EN is defined.
module tb_core_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_store_data;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic        resp_valid;
  logic        resp_wr_en;
  logic [4:0]  resp_rd;
  logic [63:0] load_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [63:0] exc_tval;

  int passed = 0;
  int total  = 0;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  core_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .resp_valid(resp_valid), .resp_wr_en(resp_wr_en), .resp_rd(resp_rd),
    .load_data(load_data), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (T); returns 1 time unit into cycle T+1.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] data,
                       input logic [4:0] rd);
    step();
    req_valid      = 1'b1;
    req_opcode     = op;
    req_funct3     = f3;
    req_addr       = addr;
    req_store_data = data;
    req_rd         = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
    total++; if ({mem_req, mem_we, mem_be} !== 10'd0) $display("FAIL reset_mem: got %h want 0", {mem_req, mem_we, mem_be}); else passed++;
    total++; if ({resp_valid, resp_wr_en, exc_valid, exc_cause, load_data} !== 71'd0) $display("FAIL reset_resp: got %h want 0", {resp_valid, resp_wr_en, exc_valid, exc_cause, load_data}); else passed++;
    rst = 1'b0;
    // Reset while in REQ drops mem_req without waiting for a clock edge.
    issue(LOAD, 3'b011, 64'h8000, 64'd0, 5'd1);
    total++; if (mem_req !== 1'b1) $display("FAIL rstreq_pre: got %b want 1", mem_req); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_req, req_ready} !== 2'b01) $display("FAIL rstreq_async: got %b want 01", {mem_req, req_ready}); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_lw_sign();
    issue(LOAD, 3'b010, 64'h1004, 64'd0, 5'd5);
    total++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 8'hF0, 64'h1000}) $display("FAIL lw_req: got %h want %h", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 8'hF0, 64'h1000}); else passed++;
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8000_0001_1234_5678;
    total++; if ({mem_req, resp_valid} !== 2'b00) $display("FAIL lw_wait: got %b want 00", {mem_req, resp_valid}); else passed++;
    step();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b1) $display("FAIL lw_resp_valid: got %b want 1", resp_valid); else passed++;
    total++; if (load_data !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw_data: got %h want ffffffff80000001", load_data); else passed++;
    total++; if ({resp_wr_en, resp_rd, exc_valid} !== {1'b1, 5'd5, 1'b0}) $display("FAIL lw_wr: got %h want %h", {resp_wr_en, resp_rd, exc_valid}, {1'b1, 5'd5, 1'b0}); else passed++;
    step();
    total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL lw_after: got %b want 01", {resp_valid, req_ready}); else passed++;
  endtask

  task automatic test_sb_lane();
    issue(STORE, 3'b000, 64'h2003, 64'h0000_0000_0000_00AB, 5'd9);
    total++; if (mem_be !== 8'h08) $display("FAIL sb_be: got %h want 08", mem_be); else passed++;
    total++; if (mem_wdata[31:24] !== 8'hAB) $display("FAIL sb_wdata: got %h want ab", mem_wdata[31:24]); else passed++;
    total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 64'h2000}) $display("FAIL sb_req: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 64'h2000}); else passed++;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    total++; if ({resp_valid, resp_wr_en, exc_valid, mem_req} !== 4'b1000) $display("FAIL sb_resp: got %b want 1000", {resp_valid, resp_wr_en, exc_valid, mem_req}); else passed++;
  endtask

  task automatic test_misaligned();
    issue(LOAD, 3'b001, 64'h3001, 64'd0, 5'd4);
    total++; if ({mem_req, resp_valid, exc_valid} !== 3'b011) $display("FAIL lh_mis_flags: got %b want 011", {mem_req, resp_valid, exc_valid}); else passed++;
    total++; if ({exc_cause, exc_tval} !== {4'd4, 64'h3001}) $display("FAIL lh_mis_cause: got %h want %h", {exc_cause, exc_tval}, {4'd4, 64'h3001}); else passed++;
    total++; if ({resp_wr_en, load_data} !== 65'd0) $display("FAIL lh_mis_data: got %h want 0", {resp_wr_en, load_data}); else passed++;
    issue(STORE, 3'b011, 64'h5004, 64'h55, 5'd0);
    total++; if ({mem_req, resp_valid, exc_valid, exc_cause} !== {3'b011, 4'd6}) $display("FAIL sd_mis: got %h want %h", {mem_req, resp_valid, exc_valid, exc_cause}, {3'b011, 4'd6}); else passed++;
    issue(STORE, 3'b100, 64'h5000, 64'h55, 5'd0);
    total++; if ({mem_req, resp_valid, exc_valid, exc_cause} !== {3'b011, 4'd2}) $display("FAIL st_illegal: got %h want %h", {mem_req, resp_valid, exc_valid, exc_cause}, {3'b011, 4'd2}); else passed++;
    issue(LOAD, 3'b111, 64'h5000, 64'h0, 5'd3);
    total++; if ({resp_valid, exc_valid, exc_cause, resp_wr_en} !== {2'b11, 4'd2, 1'b0}) $display("FAIL ld_illegal: got %h want %h", {resp_valid, exc_valid, exc_cause, resp_wr_en}, {2'b11, 4'd2, 1'b0}); else passed++;
  endtask

  task automatic test_load_fault();
    issue(LOAD, 3'b100, 64'h10, 64'd0, 5'd7);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    mem_rdata  = 64'h1234;
    step();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    total++; if ({resp_valid, exc_valid, exc_cause} !== {2'b11, 4'd5}) $display("FAIL lbu_fault_cause: got %h want %h", {resp_valid, exc_valid, exc_cause}, {2'b11, 4'd5}); else passed++;
    total++; if ({resp_wr_en, load_data, exc_tval} !== {1'b0, 64'd0, 64'h10}) $display("FAIL lbu_fault_data: got %h want %h", {resp_wr_en, load_data, exc_tval}, {1'b0, 64'd0, 64'h10}); else passed++;
  endtask

  task automatic test_lb_rd0();
    issue(LOAD, 3'b000, 64'h4005, 64'd0, 5'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_8000_0000_0000;
    step();
    mem_rvalid = 1'b0;
    total++; if (load_data !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_data: got %h want ffffffffffffff80", load_data); else passed++;
    total++; if ({resp_valid, resp_wr_en, exc_valid} !== 3'b100) $display("FAIL lb_rd0_wr: got %b want 100", {resp_valid, resp_wr_en, exc_valid}); else passed++;
  endtask

  task automatic test_stall_reset();
    issue(STORE, 3'b011, 64'h6000, 64'h1122_3344_5566_7788, 5'd2);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'hFF, 64'h6000, 64'h1122_3344_5566_7788})
        $display("FAIL stall_hold[%0d]: got %h want %h", i, {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'hFF, 64'h6000, 64'h1122_3344_5566_7788});
      else passed++;
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    total++; if ({mem_req, req_ready, resp_valid} !== 3'b000) $display("FAIL stall_wait: got %b want 000", {mem_req, req_ready, resp_valid}); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_req, req_ready} !== 2'b01) $display("FAIL wait_rst_async: got %b want 01", {mem_req, req_ready}); else passed++;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b0) $display("FAIL late_rvalid_1: got %b want 0", resp_valid); else passed++;
    step();
    total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL late_rvalid_2: got %b want 01", {resp_valid, req_ready}); else passed++;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    issue(LOAD, 3'b011, 64'h7000, 64'd0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      total++; if ({mem_req, resp_valid} !== 2'b10) $display("FAIL to_wait[%0d]: got %b want 10", i, {mem_req, resp_valid}); else passed++;
      step();
    end
    total++; if ({resp_valid, exc_valid, exc_cause, mem_req} !== {2'b11, 4'd5, 1'b0}) $display("FAIL to_fault: got %h want %h", {resp_valid, exc_valid, exc_cause, mem_req}, {2'b11, 4'd5, 1'b0}); else passed++;
    total++; if (exc_tval !== 64'h7000) $display("FAIL to_tval: got %h want 7000", exc_tval); else passed++;
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b0) $display("FAIL to_stray: got %b want 0", resp_valid); else passed++;
  endtask
`endif

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_opcode     = 7'd0;
    req_funct3     = 3'd0;
    req_addr       = 64'd0;
    req_store_data = 64'd0;
    req_rd         = 5'd0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 64'd0;
    mem_err        = 1'b0;

    test_reset();
    test_lw_sign();
    test_sb_lane();
    test_misaligned();
    test_load_fault();
    test_lb_rd0();
    test_stall_reset();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
